// File: rtl/code_sequencer_pkg.sv
// Shared types and constants for the code sequencer and its sender.
// SEQ_TIMEOUT_EN (optional) enables the per-digit done watchdog in code_sequencer.
package code_sequencer_pkg;

    localparam int DIGIT_W                = 4;
    localparam int MAX_DIGITS             = 4;
    localparam int MAX_VALID_DIGIT        = 6;
    localparam int DEFAULT_HOLD_TIME      = 1200000;
    localparam int DEFAULT_GAP_TIME       = 120000;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4800000;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        GAP,
        FIN,
        ERR
    } state_t;

    // A request is sendable only if its length is 1..MAX_DIGITS and every used digit fits the link.
    function automatic logic start_ok(input logic [MAX_DIGITS*DIGIT_W-1:0] digits,
                                      input logic [2:0]                    count);
        logic ok;
        ok = (count >= 3'd1) && (count <= 3'(MAX_DIGITS));
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < int'(count)) && (int'(digits[i*DIGIT_W +: DIGIT_W]) > MAX_VALID_DIGIT)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/code_sequencer_sender.sv
// Arduino link sender: while enabled, strobes num for holdTime cycles, then idles
// holdTime+1 cycles and raises done; dropping enable clears it back to the start.
module code_sequencer_sender #(
    parameter int holdTime = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] num,
    output logic       out0,
    output logic       out1,
    output logic       out2,
    output logic       controlOut,
    output logic       done
);

    localparam int LAST  = 2 * holdTime + 1;
    localparam int CNT_W = $clog2(LAST + 1);

    logic [CNT_W-1:0] cnt;
    logic             strobe;

    // cnt counts enabled cycles and saturates at LAST, where done is presented.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign strobe     = (cnt != '0) && (cnt <= CNT_W'(holdTime));
    assign controlOut = strobe;
    assign out0       = strobe & num[0];
    assign out1       = strobe & num[1];
    assign out2       = strobe & num[2];
    assign done       = (cnt == CNT_W'(LAST));

endmodule

// File: rtl/code_sequencer.sv
// Sends up to four latched digits over the Arduino link, one sender strobe per digit.
// Define SEQ_TIMEOUT_EN to add a watchdog that aborts a digit whose done never arrives.
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int HOLD_TIME      = DEFAULT_HOLD_TIME,
    parameter int GAP_TIME       = DEFAULT_GAP_TIME,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        hwclk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] digits,
    input  logic [2:0]  count,
    output logic        busy,
    output logic        finished,
    output logic        err,
    output logic        out0,
    output logic        out1,
    output logic        out2,
    output logic        controlOut
);

    localparam int GAP_W = $clog2(GAP_TIME + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIME - 1);

    state_t state, state_n;

    logic [MAX_DIGITS-1:0][2:0] digits_q;
    logic [2:0]                 count_q;
    logic [1:0]                 idx;
    logic [GAP_W-1:0]           gap_cnt;
    logic                       accept;
    logic                       last_digit;
    logic                       gap_end;
    logic                       enable;
    logic                       sender_done;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign accept     = start_ok(digits, count);
    assign last_digit = (({1'b0, idx} + 3'd1) == count_q);
    assign gap_end    = (gap_cnt == GAP_LAST);

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        enable   = 1'b0;
        busy     = 1'b0;
        finished = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = accept ? SEND : ERR;
                end
            end
            SEND: begin
                enable = 1'b1;
                busy   = 1'b1;
                if (sender_done) begin
                    state_n = GAP;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_n = ERR;
                end
`endif
            end
            GAP: begin
                busy = 1'b1;
                if (gap_end) begin
                    state_n = last_digit ? FIN : SEND;
                end
            end
            FIN: begin
                busy     = 1'b1;
                finished = 1'b1;
                state_n  = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, digit index and gap timer; the index stops at count-1 and is cleared for the next request.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            digits_q <= '0;
            count_q  <= '0;
            idx      <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == IDLE && start && accept) begin
                for (int i = 0; i < MAX_DIGITS; i++) begin
                    digits_q[i] <= digits[i*DIGIT_W +: 3];
                end
                count_q <= count;
                idx     <= '0;
            end
            if (state == GAP && !gap_end) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (state == GAP && gap_end) begin
                idx <= last_digit ? 2'd0 : idx + 2'd1;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge hwclk) begin
        if (rst || state != SEND || state_n != SEND) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    code_sequencer_sender #(
        .holdTime (HOLD_TIME)
    ) u_sender (
        .clk        (hwclk),
        .rst        (rst),
        .enable     (enable),
        .num        (digits_q[idx]),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .controlOut (controlOut),
        .done       (sender_done)
    );

endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 Parameter HOLD_TIME, default 1200000: strobe-high cycles per digit, passed to the sender instance.
REQ-002 Parameter GAP_TIME, default 120000: idle cycles between digits, with sender disabled.
REQ-003 Parameter TIMEOUT_CYCLES, default 4800000: per-digit done watchdog, used only under SEQ_TIMEOUT_EN.
REQ-004 hwclk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to send a code.
REQ-007 digits  in  16  four 4-bit digits; digits[3:0] is sent first.
REQ-008 count  in  3  number of digits to send; 1..4 valid.
REQ-009 busy  out  1  high from accepted start until return to IDLE.
REQ-010 finished  out  1  one-cycle pulse when the last digit's gap ends.
REQ-011 err  out  1  one-cycle pulse on a rejected start or a timeout.
REQ-012 out0, out1, out2, controlOut  out  1 each  Arduino link, driven only by the internal sender.

Function
REQ-013 The FSM SHALL have the states IDLE, SEND, GAP, FIN and ERR.
REQ-014 In IDLE, start SHALL be accepted only if count is in 1..4 and every used digit is ≤6.
- Accepted start: latch digits and count, index=0, go to SEND next cycle, busy=1 from that cycle.
REQ-015 A rejected start SHALL go to ERR for one cycle (err=1, busy=0) and then return to IDLE with nothing sent.
- Rejected when count=0, count>4, or any used digit ≥7.
REQ-016 In SEND, sender enable SHALL be 1 and num SHALL be latched digit[index].
REQ-017 The FSM SHALL leave SEND for GAP on the first cycle done=1 is sampled, and enable SHALL drop in that same transition.
REQ-018 GAP SHALL last exactly GAP_TIME cycles with enable=0.
- Then index increments.
- If index equals latched count, go to FIN; otherwise go to SEND.
REQ-019 FIN SHALL assert finished for one cycle, keep busy=1 during that cycle, and return to IDLE.
REQ-020 start SHALL be ignored while busy=1, with no effect on the latched data.
REQ-021 The index counter SHALL be 2 bits and SHALL never wrap past count-1.
- The gap counter SHALL be wide enough for GAP_TIME with no overflow.
REQ-022 With HOLD_TIME=H, each digit SHALL hold controlOut high for exactly H cycles.
- done is seen 2H+2 cycles after enable rises.

Reset
REQ-023 On rst=1 the block SHALL go to IDLE with index=0, counters=0, busy=0, finished=0, err=0 and enable=0.
REQ-024 Reset in mid-sequence SHALL abort the sequence.
- out0..2 and controlOut read 0 no later than one cycle after rst is sampled.
- No finished pulse is issued.
REQ-025 If start is sampled in the same cycle as rst=1, it SHALL be ignored.

Configuration
REQ-026 With SEQ_TIMEOUT_EN defined, a SEND state lasting TIMEOUT_CYCLES cycles without done SHALL be a timeout.
- Drop enable, go to ERR (err pulse), then IDLE.
- finished is not asserted.
REQ-027 Without SEQ_TIMEOUT_EN, SEND SHALL wait for done indefinitely, no watchdog logic SHALL exist, and err SHALL come only from rejected starts.

Structure
REQ-028 A shared package SHALL hold the state enumeration, DIGIT_W=4, MAX_DIGITS=4, MAX_VALID_DIGIT=6, and the default HOLD_TIME, GAP_TIME and TIMEOUT_CYCLES.
REQ-029 The existing sender SHALL be the one sub-module, instantiated inside code_sequencer.
- HOLD_TIME maps to its holdTime.
- Its outputs go straight to the ports.

Verification (bench with HOLD_TIME=4, GAP_TIME=3, TIMEOUT_CYCLES=20)
REQ-030 start, count=3, digits=0x0521 -> num 1, 2, 5 in order.
- controlOut high 4 cycles per digit; gaps of 3 cycles with all outputs 0.
- finished pulses once, then busy=0.
REQ-031 start with count=0, count=5, or digits=0x0071 with count=2 -> err pulses one cycle, controlOut never rises, busy stays 0.
REQ-032 start pulsed again during the second digit of a count=4 sequence -> ignored; exactly 4 digits sent, one finished pulse.
REQ-033 rst asserted mid-SEND of digit 2 -> next cycle state is IDLE and busy=0.
- Outputs 0 within one cycle; no finished pulse.
- A fresh start afterwards sends correctly.
REQ-034 SEQ_TIMEOUT_EN defined, sender done forced 0 -> err pulses 20 cycles after SEND entry, then IDLE.
REQ-035 count=1, digits=0x0006 -> out2=1, out1=1, out0=0 during the strobe, and finished follows the single gap.
